// File: rtl/rock_drive.sv
// Triangle position setpoint generator for the cradle actuator. Frequency and
// amplitude requests are edge-detected, saturated, and applied at upward zero crossings.
module rock_drive #(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned FREQ_W    = 8,
    parameter int unsigned FREQ_INIT = 32,
    parameter int unsigned FREQ_MIN  = 4,
    parameter int unsigned FREQ_MAX  = 200,
    parameter int unsigned FSTEP     = 4,
    parameter int unsigned AMP_W     = 8,
    parameter int unsigned AMP_INIT  = 100,
    parameter int unsigned AMP_MIN   = 10,
    parameter int unsigned AMP_MAX   = 127,
    parameter int unsigned ASTEP     = 8,
    parameter int unsigned RECOVER   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    amin,
    input  logic                    fplus,
    input  logic                    fmin,
    output logic signed [AMP_W:0]   pos,
    output logic                    dir,
    output logic                    period_done,
    output logic [FREQ_W-1:0]       freq_cur,
    output logic [AMP_W-1:0]        amp_cur
);

    localparam int unsigned CNT_W = (RECOVER > 1) ? $clog2(RECOVER) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RECOVER - 1);

    localparam logic [FREQ_W-1:0]  F_INIT    = FREQ_W'(FREQ_INIT);
    localparam logic [FREQ_W-1:0]  F_MIN     = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0]  F_MAX     = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0]  F_STEP    = FREQ_W'(FSTEP);
    localparam logic [FREQ_W:0]    F_STEP_X  = (FREQ_W+1)'(FSTEP);
    localparam logic [FREQ_W:0]    F_MAX_X   = (FREQ_W+1)'(FREQ_MAX);
    localparam logic [FREQ_W:0]    F_LOW_X   = (FREQ_W+1)'(FREQ_MIN + FSTEP);

    localparam logic [AMP_W-1:0]   A_INIT    = AMP_W'(AMP_INIT);
    localparam logic [AMP_W-1:0]   A_MIN     = AMP_W'(AMP_MIN);
    localparam logic [AMP_W-1:0]   A_MAX     = AMP_W'(AMP_MAX);
    localparam logic [AMP_W-1:0]   A_STEP    = AMP_W'(ASTEP);
    localparam logic [AMP_W:0]     A_ONE_X   = (AMP_W+1)'(1);
    localparam logic [AMP_W:0]     A_MAX_X   = (AMP_W+1)'(AMP_MAX);
    localparam logic [AMP_W:0]     A_LOW_X   = (AMP_W+1)'(AMP_MIN + ASTEP);

    localparam logic signed [AMP_W:0] POS_ONE = (AMP_W+1)'(1);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic signed [AMP_W:0]   pos_q, pos_d;
    dir_e                    dir_q, dir_d;
    logic                    pd_q;
    logic [FREQ_W-1:0]       freq_cur_q, freq_cur_d;
    logic [FREQ_W-1:0]       freq_pend_q, freq_pend_d;
    logic [AMP_W-1:0]        amp_cur_q, amp_cur_d;
    logic [AMP_W-1:0]        amp_pend_q, amp_pend_d;
    logic [CNT_W-1:0]        rec_cnt_q, rec_cnt_d;
    logic                    amin_h_q, fplus_h_q, fmin_h_q;

    logic                    amin_req, fplus_req, fmin_req;
    logic [ACC_W:0]          acc_sum;
    logic                    tick;
    logic                    xing;
    logic signed [AMP_W:0]   amp_s;
    logic [FREQ_W:0]         freq_up;
    logic [AMP_W:0]          amp_up;

    assign amin_req  = amin  & ~amin_h_q;
    assign fplus_req = fplus & ~fplus_h_q;
    assign fmin_req  = fmin  & ~fmin_h_q;

    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(freq_cur_q);
    assign tick    = acc_sum[ACC_W];
    assign acc_d   = acc_sum[ACC_W-1:0];

    assign amp_s   = signed'({1'b0, amp_cur_q});
    assign freq_up = {1'b0, freq_pend_q} + F_STEP_X;
    assign amp_up  = {1'b0, amp_pend_q} + A_ONE_X;

    // Triangle stepping; a crossing is any tick that lands pos on 0 coming from -1.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        xing  = 1'b0;
        if (tick) begin
            if (amp_cur_q == '0) begin
                pos_d = '0;
                dir_d = DIR_UP;
                xing  = 1'b1;
            end else begin
                if (dir_q == DIR_UP) begin
                    if (pos_q == amp_s) begin
                        dir_d = DIR_DOWN;
                        pos_d = pos_q - POS_ONE;
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                end else begin
                    if (pos_q == -amp_s) begin
                        dir_d = DIR_UP;
                        pos_d = pos_q + POS_ONE;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end
                xing = (pos_q == '1) && (pos_d == '0);
            end
        end
    end

    always_comb begin
        freq_pend_d = freq_pend_q;
        if (fplus_req && !fmin_req) begin
            freq_pend_d = (freq_up > F_MAX_X) ? F_MAX : freq_up[FREQ_W-1:0];
        end else if (fmin_req && !fplus_req) begin
            freq_pend_d = ({1'b0, freq_pend_q} < F_LOW_X) ? F_MIN : (freq_pend_q - F_STEP);
        end
    end

    // An amin request pre-empts a recovery step falling on the same edge.
    always_comb begin
        amp_pend_d = amp_pend_q;
        rec_cnt_d  = rec_cnt_q;
        if (amin_req) begin
            amp_pend_d = ({1'b0, amp_pend_q} < A_LOW_X) ? A_MIN : (amp_pend_q - A_STEP);
            rec_cnt_d  = '0;
        end else if (xing) begin
            if (rec_cnt_q == CNT_LAST) begin
                rec_cnt_d  = '0;
                amp_pend_d = (amp_up > A_MAX_X) ? A_MAX : amp_up[AMP_W-1:0];
            end else begin
                rec_cnt_d  = rec_cnt_q + CNT_W'(1);
            end
        end
    end

    // Setpoints load from the next-state pending values so a same-edge request is kept.
    assign freq_cur_d = xing ? freq_pend_d : freq_cur_q;
    assign amp_cur_d  = xing ? amp_pend_d  : amp_cur_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            pd_q        <= 1'b0;
            freq_cur_q  <= F_INIT;
            freq_pend_q <= F_INIT;
            amp_cur_q   <= A_INIT;
            amp_pend_q  <= A_INIT;
            rec_cnt_q   <= '0;
            amin_h_q    <= 1'b1;
            fplus_h_q   <= 1'b1;
            fmin_h_q    <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            pd_q        <= xing;
            freq_cur_q  <= freq_cur_d;
            freq_pend_q <= freq_pend_d;
            amp_cur_q   <= amp_cur_d;
            amp_pend_q  <= amp_pend_d;
            rec_cnt_q   <= rec_cnt_d;
            amin_h_q    <= amin;
            fplus_h_q   <= fplus;
            fmin_h_q    <= fmin;
        end
    end

    assign pos         = pos_q;
    assign dir         = dir_q;
    assign period_done = pd_q;
    assign freq_cur    = freq_cur_q;
    assign amp_cur     = amp_cur_q;

endmodule
